// File: rtl/gbe_pkg.sv
// Shared defaults and FSM state encoding for the GbE ARP cache arbiter.
package gbe_pkg;

  localparam int GBE_ADDR_W = 8;
  localparam int GBE_DATA_W = 48;

  // Lookup FSM: IDLE waits for a request, RD is the cycle the RAM returns data.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RD   = 1'b1;

endpackage

// File: rtl/gbe_arp_cache_arb.sv
// ARP cache RAM arbiter: the CPU attach owns the single-port RAM whenever it
// is active, and next-hop MAC lookups from the tx engine fill the free cycles.
module gbe_arp_cache_arb
  import gbe_pkg::*;
#(
  parameter int ADDR_W       = GBE_ADDR_W,
  parameter int DATA_W       = GBE_DATA_W,
  parameter int MAX_WAIT     = 64,
  parameter int MISS_ON_ZERO = 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cpu_active,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  input  logic              cpu_wr_en,
  output logic [DATA_W-1:0] cpu_rd_data,
  input  logic              lkp_req,
  input  logic [ADDR_W-1:0] lkp_addr,
  output logic              lkp_ack,
  output logic              lkp_valid,
  output logic [DATA_W-1:0] lkp_data,
  output logic              lkp_miss,
  output logic              lkp_starved,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              ram_wr_en,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic [15:0]       stat_lkp_cnt,
  output logic [15:0]       stat_defer_cnt
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic              cpu_own;
  logic              issue;
  logic              defer;
  logic              rd_miss;
  logic [0:0]        state;
  logic [0:0]        state_next;
  logic [DATA_W-1:0] data_q;
  logic              miss_q;
  logic [WAIT_W-1:0] wait_cnt;

  // The CPU cannot be stalled, so it takes the RAM in the same cycle it asks.
  assign cpu_own     = cpu_active | cpu_wr_en;
  assign ram_addr    = cpu_own ? cpu_addr : lkp_addr;
  assign ram_wr_data = cpu_wr_data;
  assign ram_wr_en   = cpu_wr_en;
  assign cpu_rd_data = ram_rd_data;

  // A lookup is issued in any cycle the CPU leaves free, including the RD
  // cycle, which gives back-to-back lookups at one per clock.
  assign issue   = ~wb_rst_i & lkp_req & ~cpu_own;
  assign defer   = lkp_req & cpu_own & (state == ST_IDLE);
  assign lkp_ack = issue;

  // Read data is presented live in the RD cycle and held afterwards, so the
  // requester sees its MAC one cycle after the ack.
  assign rd_miss   = (MISS_ON_ZERO != 0) && (ram_rd_data == '0);
  assign lkp_valid = ~wb_rst_i & (state == ST_RD);
  assign lkp_data  = lkp_valid ? ram_rd_data : data_q;
  assign lkp_miss  = lkp_valid ? rd_miss : miss_q;

  // Next-state selection: any issue lands in RD, everything else in IDLE.
  always_comb begin
    state_next = ST_IDLE;
    case (state)
      ST_IDLE: if (issue) state_next = ST_RD;
      ST_RD:   if (issue) state_next = ST_RD;
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM register plus the held copy of the last lookup result.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state  <= ST_IDLE;
      data_q <= '0;
      miss_q <= 1'b0;
    end else begin
      state <= state_next;
      if (lkp_valid) begin
        data_q <= ram_rd_data;
        miss_q <= rd_miss;
      end
    end
  end

  // Wait counter and sticky starvation flag for a request the CPU keeps out.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wait_cnt    <= '0;
      lkp_starved <= 1'b0;
    end else begin
      if (!lkp_req || issue) begin
        wait_cnt <= '0;
      end else if (defer && wait_cnt != WAIT_W'(MAX_WAIT)) begin
        wait_cnt <= wait_cnt + 1'b1;
        if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) lkp_starved <= 1'b1;
      end
    end
  end

  // Statistics: completed lookups wrap, deferred cycles saturate.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      stat_lkp_cnt   <= '0;
      stat_defer_cnt <= '0;
    end else begin
      if (lkp_valid) stat_lkp_cnt <= stat_lkp_cnt + 16'd1;
      if (defer && stat_defer_cnt != 16'hFFFF) stat_defer_cnt <= stat_defer_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_gbe_arp_cache_arb.sv
// Randomized and directed bench for gbe_arp_cache_arb with a behavioural RAM
// and a transaction-level reference model of arbitration and lookups.
module tb_gbe_arp_cache_arb;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 48;
  localparam int MAX_WAIT = 64;

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_i;
  logic              cpu_active;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wr_data;
  logic              cpu_wr_en;
  logic [DATA_W-1:0] cpu_rd_data;
  logic              lkp_req;
  logic [ADDR_W-1:0] lkp_addr;
  logic              lkp_ack;
  logic              lkp_valid;
  logic [DATA_W-1:0] lkp_data;
  logic              lkp_miss;
  logic              lkp_starved;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wr_data;
  logic              ram_wr_en;
  logic [DATA_W-1:0] ram_rd_data = '0;
  logic [15:0]       stat_lkp_cnt;
  logic [15:0]       stat_defer_cnt;

  // Behavioural single-port RAM, read-before-write, one cycle read latency.
  logic [DATA_W-1:0] ram_mem [0:255];

  // Reference model state.
  logic [DATA_W-1:0] m_mem [0:255];
  bit                m_inflight;
  logic [DATA_W-1:0] m_inflight_data;
  logic [DATA_W-1:0] m_held_data;
  bit                m_held_miss;
  int                m_lkp_cnt;
  int                m_defer_cnt;
  int                m_wait;
  bit                m_starved;
  logic [DATA_W-1:0] m_prev_read;
  bit                m_rd_known;
  bit                last_ack;

  int checks = 0;
  int passed = 0;

  gbe_arp_cache_arb #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .MISS_ON_ZERO(1)
  ) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .cpu_active(cpu_active), .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data),
    .cpu_wr_en(cpu_wr_en), .cpu_rd_data(cpu_rd_data),
    .lkp_req(lkp_req), .lkp_addr(lkp_addr), .lkp_ack(lkp_ack),
    .lkp_valid(lkp_valid), .lkp_data(lkp_data), .lkp_miss(lkp_miss),
    .lkp_starved(lkp_starved),
    .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .ram_wr_en(ram_wr_en),
    .ram_rd_data(ram_rd_data),
    .stat_lkp_cnt(stat_lkp_cnt), .stat_defer_cnt(stat_defer_cnt)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  always @(posedge wb_clk_i) begin
    if (ram_wr_en) ram_mem[ram_addr] <= ram_wr_data;
    ram_rd_data <= ram_mem[ram_addr];
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed === expected) passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input bit rst, input bit req, input logic [7:0] laddr,
                               input bit active, input logic [7:0] caddr,
                               input bit wen, input logic [47:0] wdata);
    wb_rst_i    = rst;
    lkp_req     = req;
    lkp_addr    = laddr;
    cpu_active  = active;
    cpu_addr    = caddr;
    cpu_wr_en   = wen;
    cpu_wr_data = wdata;
  endtask

  // One clock: compare every output against the model just after the
  // inputs settle, then advance the model across the rising edge.
  task automatic clockCycle();
    bit                own, e_ack, e_valid, e_miss, deferred;
    logic [DATA_W-1:0] e_data;
    logic [ADDR_W-1:0] e_addr;
    #1;
    own     = cpu_active | cpu_wr_en;
    e_ack   = !wb_rst_i && lkp_req && !own;
    e_valid = !wb_rst_i && m_inflight;
    e_data  = e_valid ? m_inflight_data : m_held_data;
    e_miss  = e_valid ? (m_inflight_data == '0) : m_held_miss;
    e_addr  = own ? cpu_addr : lkp_addr;
    checkOutput("lkp_ack", 64'(lkp_ack), 64'(e_ack));
    checkOutput("lkp_valid", 64'(lkp_valid), 64'(e_valid));
    checkOutput("lkp_data", 64'(lkp_data), 64'(e_data));
    checkOutput("lkp_miss", 64'(lkp_miss), 64'(e_miss));
    checkOutput("ram_addr", 64'(ram_addr), 64'(e_addr));
    checkOutput("ram_wr_en", 64'(ram_wr_en), 64'(cpu_wr_en));
    if (own) checkOutput("ram_wr_data", 64'(ram_wr_data), 64'(cpu_wr_data));
    if (m_rd_known) checkOutput("cpu_rd_data", 64'(cpu_rd_data), 64'(m_prev_read));
    checkOutput("lkp_starved", 64'(lkp_starved), 64'(m_starved));
    checkOutput("stat_lkp_cnt", 64'(stat_lkp_cnt), 64'(m_lkp_cnt[15:0]));
    checkOutput("stat_defer_cnt", 64'(stat_defer_cnt), 64'(m_defer_cnt));
    @(posedge wb_clk_i);
    deferred    = lkp_req && own && !m_inflight;
    m_prev_read = m_mem[e_addr];
    m_rd_known  = 1'b1;
    if (wb_rst_i) begin
      m_inflight  = 1'b0;
      m_held_data = '0;
      m_held_miss = 1'b0;
      m_lkp_cnt   = 0;
      m_defer_cnt = 0;
      m_wait      = 0;
      m_starved   = 1'b0;
    end else begin
      if (e_valid) begin
        m_held_data = m_inflight_data;
        m_held_miss = (m_inflight_data == '0);
        m_lkp_cnt   = (m_lkp_cnt + 1) % 65536;
      end
      if (deferred && m_defer_cnt < 65535) m_defer_cnt++;
      if (!lkp_req || e_ack) m_wait = 0;
      else if (deferred && m_wait < MAX_WAIT) begin
        m_wait++;
        if (m_wait == MAX_WAIT) m_starved = 1'b1;
      end
      m_inflight = e_ack;
      if (e_ack) m_inflight_data = m_mem[lkp_addr];
    end
    if (cpu_wr_en) m_mem[cpu_addr] = cpu_wr_data;
    last_ack = e_ack;
    @(negedge wb_clk_i);
  endtask

  task automatic runRandom(input int n);
    logic [63:0] r;
    for (int i = 0; i < n; i++) begin
      r = {$urandom(), $urandom()};
      if (last_ack || !lkp_req) begin
        lkp_req  = ($urandom_range(0, 3) != 0);
        lkp_addr = 8'($urandom_range(0, 255));
      end
      cpu_active  = ($urandom_range(0, 3) == 0);
      cpu_wr_en   = ($urandom_range(0, 7) == 0);
      cpu_addr    = 8'($urandom_range(0, 255));
      cpu_wr_data = ($urandom_range(0, 5) == 0) ? 48'h0 : r[47:0];
      wb_rst_i    = ($urandom_range(0, 149) == 0);
      clockCycle();
    end
  endtask

  initial begin
    logic [63:0] r;
    for (int a = 0; a < 256; a++) begin
      r = {$urandom(), $urandom()};
      ram_mem[a] = r[47:0];
      m_mem[a]   = r[47:0];
    end
    ram_mem[8'h05] = 48'h0011_2233_4455; m_mem[8'h05] = 48'h0011_2233_4455;
    ram_mem[8'h20] = 48'h0;              m_mem[8'h20] = 48'h0;
    m_inflight = 0; m_inflight_data = '0; m_held_data = '0; m_held_miss = 0;
    m_lkp_cnt = 0; m_defer_cnt = 0; m_wait = 0; m_starved = 0;
    m_prev_read = '0; m_rd_known = 0; last_ack = 0;

    applyStimulus(1, 0, 8'h00, 0, 8'h00, 0, 48'h0);
    @(negedge wb_clk_i);
    clockCycle();
    clockCycle();

    // Basic lookup.
    applyStimulus(0, 1, 8'h05, 0, 8'h00, 0, 48'h0);
    clockCycle();
    applyStimulus(0, 0, 8'h05, 0, 8'h00, 0, 48'h0);
    clockCycle();
    checkOutput("tp_basic_data", 64'(lkp_data), 64'h0011_2233_4455);
    checkOutput("tp_basic_miss", 64'(lkp_miss), 64'h0);
    checkOutput("tp_basic_cnt", 64'(stat_lkp_cnt), 64'd1);

    // CPU holds the RAM for ten cycles.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 1, 8'h33, 1, 8'(8'h80 + i), 0, 48'h0);
      clockCycle();
    end
    checkOutput("tp_defer_cnt", 64'(stat_defer_cnt), 64'd10);
    applyStimulus(0, 1, 8'h33, 0, 8'h00, 0, 48'h0);
    clockCycle();
    applyStimulus(0, 0, 8'h33, 0, 8'h00, 0, 48'h0);
    clockCycle();

    // CPU write, then lookup of the written entry.
    applyStimulus(0, 0, 8'h00, 0, 8'h10, 1, 48'hAABB_CCDD_EEFF);
    clockCycle();
    applyStimulus(0, 1, 8'h10, 0, 8'h00, 0, 48'h0);
    clockCycle();
    applyStimulus(0, 0, 8'h10, 0, 8'h00, 0, 48'h0);
    clockCycle();
    checkOutput("tp_rmw_data", 64'(lkp_data), 64'hAABB_CCDD_EEFF);

    // Back-to-back lookups.
    for (int a = 1; a <= 3; a++) begin
      applyStimulus(0, 1, 8'(a), 0, 8'h00, 0, 48'h0);
      clockCycle();
    end
    applyStimulus(0, 0, 8'h00, 0, 8'h00, 0, 48'h0);
    clockCycle();

    // Zero entry reports a miss.
    applyStimulus(0, 1, 8'h20, 0, 8'h00, 0, 48'h0);
    clockCycle();
    applyStimulus(0, 0, 8'h20, 0, 8'h00, 0, 48'h0);
    clockCycle();
    checkOutput("tp_miss", 64'(lkp_miss), 64'h1);

    // CPU write to the same entry right after issue returns the old entry.
    applyStimulus(0, 1, 8'h05, 0, 8'h00, 0, 48'h0);
    clockCycle();
    applyStimulus(0, 0, 8'h05, 0, 8'h05, 1, 48'h1234_5678_9ABC);
    clockCycle();
    checkOutput("tp_hazard_old", 64'(lkp_data), 64'h0011_2233_4455);

    // Starvation.
    for (int i = 0; i < 70; i++) begin
      applyStimulus(0, 1, 8'h07, 1, 8'h00, 0, 48'h0);
      clockCycle();
    end
    checkOutput("tp_starved", 64'(lkp_starved), 64'h1);
    applyStimulus(0, 1, 8'h07, 0, 8'h00, 0, 48'h0);
    clockCycle();
    applyStimulus(0, 0, 8'h07, 0, 8'h00, 0, 48'h0);
    clockCycle();
    checkOutput("tp_starved_sticky", 64'(lkp_starved), 64'h1);

    // Reset during the RD cycle.
    applyStimulus(0, 1, 8'h05, 0, 8'h00, 0, 48'h0);
    clockCycle();
    applyStimulus(1, 0, 8'h05, 0, 8'h00, 0, 48'h0);
    clockCycle();
    applyStimulus(0, 0, 8'h05, 0, 8'h00, 0, 48'h0);
    #1;
    checkOutput("tp_rst_valid", 64'(lkp_valid), 64'h0);
    checkOutput("tp_rst_data", 64'(lkp_data), 64'h0);
    checkOutput("tp_rst_starved", 64'(lkp_starved), 64'h0);
    checkOutput("tp_rst_lkp_cnt", 64'(stat_lkp_cnt), 64'h0);
    checkOutput("tp_rst_defer_cnt", 64'(stat_defer_cnt), 64'h0);
    @(negedge wb_clk_i);

    runRandom(600);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/gbe_arp_cache_arb.md
Name: gbe_arp_cache_arb

Overview:
- Shares the single-port 256x48 ARP cache RAM between two requesters: the CPU attach (wishbone register/RMW path) and the UDP transmit engine's next-hop MAC lookup.
- The CPU always wins, because the CPU attach cannot be stalled. The lookup is served in cycles the CPU leaves free.
- Also provides lookup handshaking, starvation detection, miss flagging and statistics.
- Sits between gbe_cpu_attach, the tx engine and the ARP cache RAM, in the wishbone clock domain.

Parameters:
- ADDR_W, 8, ARP cache address width (entries = 2**ADDR_W).
- DATA_W, 48, entry width (MAC address).
- MAX_WAIT, 64, cycles a pending lookup may wait before lkp_starved is flagged.
- MISS_ON_ZERO, 1, if 1 an all-zero entry is reported as a lookup miss.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset
- cpu_active  in  1  CPU is addressing the ARP range (arp_sel && cyc)
- cpu_addr  in  ADDR_W  CPU entry address
- cpu_wr_data  in  DATA_W  CPU write data
- cpu_wr_en  in  1  CPU write strobe
- cpu_rd_data  out  DATA_W  RAM read data to CPU
- lkp_req  in  1  lookup request, held until lkp_ack
- lkp_addr  in  ADDR_W  lookup entry address, stable while lkp_req
- lkp_ack  out  1  one-cycle pulse: request issued to RAM
- lkp_valid  out  1  one-cycle pulse: lkp_data/lkp_miss valid
- lkp_data  out  DATA_W  looked-up MAC, held until next lkp_valid
- lkp_miss  out  1  entry is unresolved, qualified by lkp_valid
- lkp_starved  out  1  sticky: a request waited more than MAX_WAIT cycles
- ram_addr  out  ADDR_W  RAM address
- ram_wr_data  out  DATA_W  RAM write data
- ram_wr_en  out  1  RAM write enable
- ram_rd_data  in  DATA_W  RAM read data, registered, 1-cycle latency
- stat_lkp_cnt  out  16  completed lookups, wrapping
- stat_defer_cnt  out  16  cycles a request was deferred by the CPU, saturating at 16'hFFFF

Behaviour:
- Single clock wb_clk_i. Synchronous active-high reset wb_rst_i.
- Reset values: lkp_ack=0, lkp_valid=0, lkp_data=0, lkp_miss=0, lkp_starved=0, both stats=0, FSM=IDLE, wait counter=0.
- Ownership: cpu_own = cpu_active | cpu_wr_en. This is combinational, same cycle.
- When cpu_own is high:
  - ram_addr=cpu_addr, ram_wr_data=cpu_wr_data, ram_wr_en=cpu_wr_en.
  - The CPU never sees extra latency.
- When cpu_own is low: ram_addr=lkp_addr, ram_wr_en=0.
- cpu_rd_data = ram_rd_data unconditionally. The CPU timing (address at t, data at t+1) is preserved.
- FSM:
  - IDLE, with lkp_req=1 and cpu_own=0: issue, pulse lkp_ack, go to RD.
  - IDLE, with lkp_req=1 and cpu_own=1: stay in IDLE, increment the wait counter and stat_defer_cnt.
  - RD: next cycle, capture ram_rd_data into lkp_data, pulse lkp_valid, increment stat_lkp_cnt.
  - RD, new request: if lkp_req is high again with cpu_own=0 in the RD cycle, issue immediately (ack in the same cycle as valid) and stay in RD. Peak rate is 1 lookup/cycle.
  - RD, otherwise: go to IDLE.
- The requester must drop lkp_req, or present a new address, in the cycle after lkp_ack.
- cpu_own rising while in RD does not corrupt the in-flight lookup: the read address was registered by the RAM on the issue edge.
- lkp_miss = MISS_ON_ZERO && (ram_rd_data == 0), registered with lkp_data.
- Wait counter:
  - Clears on lkp_ack or when lkp_req=0. Saturates at MAX_WAIT.
  - Reaching MAX_WAIT sets lkp_starved, which clears only on reset.
- Hazards:
  - A CPU write in the cycle after a lookup issue to the same address: the lookup returns the old entry. This is the defined behaviour.
  - A CPU write and a lookup request in the same cycle: the CPU writes and the lookup is deferred.
- Reset mid-lookup: the FSM returns to IDLE with no lkp_valid. The requester re-requests.

Decomposition:
- Package gbe_pkg: ADDR_W/DATA_W defaults and the FSM state encoding (IDLE, RD).
- No sub-module. The saturating 16-bit counter may be written as a small local generate block.

Test Plan:
- Reset, then lkp_req with addr 8'h05 and entry 48'h0011_2233_4455, cpu_active=0 -> lkp_ack at t, lkp_valid at t+1, lkp_data=48'h0011_2233_4455, lkp_miss=0, stat_lkp_cnt=1.
- cpu_active=1 for 10 cycles while lkp_req is held -> no lkp_ack, ram_addr tracks cpu_addr, stat_defer_cnt=10. Ack lands in the first cycle cpu_active=0.
- CPU RMW write 48'hAABB_CCDD_EEFF to addr 8'h10 (cpu_wr_en with cpu_active=0), then lookup 8'h10 -> ram_wr_en in the write cycle, lookup returns 48'hAABB_CCDD_EEFF.
- Back-to-back lookups at addresses 1, 2, 3 with the CPU idle -> three acks and three valids on consecutive cycles, data in address order.
- Entry 0 at addr 8'h20 with MISS_ON_ZERO=1 -> lkp_valid with lkp_miss=1. cpu_active held for 70 cycles with MAX_WAIT=64 -> lkp_starved=1, remains set after the request completes.
- wb_rst_i asserted in the RD cycle -> no lkp_valid, all outputs return to their reset values next cycle.
